// File: rtl/cache_arbiter.sv
// Shares one memory line port between icache and dcache misses, one transaction at a time.
// Grant seen on pmem_* one cycle after request; requesters are held off by withholding resp.
module cache_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_write;
    logic [LINE_W-1:0] lat_wdata;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;
    logic              serve_i;
    logic              serve_d;

    assign d_req   = d_read | d_write;
    // icache only loses to the dcache until it has been passed over MAX_WAIT times
    assign grant_i = (state == IDLE) && i_read && (!d_req || (wait_cnt == WAIT_MAX));
    assign grant_d = (state == IDLE) && d_req && !grant_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = SERVE_I;
                end else if (grant_d) begin
                    state_nxt = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
        end else if (grant_i) begin
            lat_addr  <= i_address;
            lat_write <= 1'b0;
            wait_cnt  <= '0;
        end else if (grant_d) begin
            // read+write together is treated as a write-back
            lat_addr  <= d_address;
            lat_write <= d_write;
            lat_wdata <= d_wdata;
            if (!i_read) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign serve_i      = (state == SERVE_I);
    assign serve_d      = (state == SERVE_D);
    assign pmem_read    = serve_i | (serve_d & ~lat_write);
    assign pmem_write   = serve_d & lat_write;
    assign pmem_address = (serve_i | serve_d) ? lat_addr : '0;
    assign pmem_wdata   = pmem_write ? lat_wdata : '0;
    assign i_resp       = serve_i & pmem_resp;
    assign d_resp       = serve_d & pmem_resp;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected memory transactions are queued
// in grant order and matched against the pmem port and resp routing.
module tb_cache_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    cache_arbiter #(.ADDR_W(32), .LINE_W(256), .MAX_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct {
        bit           is_d;
        bit           write;
        bit           abort;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           exp_cyc;   // absolute grant cycle, or -1 for "third cycle after last resp"
    } txn_t;

    txn_t sb[$];
    txn_t cur;
    bit   active      = 0;
    bit   mem_en      = 1;
    bit   stray_pulse = 0;
    logic serving;
    int   cyc         = 0;
    int   last_resp   = 0;
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   i_cnt       = 0;
    int   d_cnt       = 0;
    int   i_exp       = 0;
    int   d_exp       = 0;
    int   mcnt        = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] model_rdata(input logic [31:0] a);
        return {8{a ^ 32'h4000_0020 ^ 32'hA5A5_A5A5}};
    endfunction

    task automatic push(input bit is_d, input bit write, input bit abort, input logic [31:0] addr,
                        input logic [255:0] wdata, input logic [255:0] rdata, input int exp_cyc);
        txn_t t;
        t.is_d = is_d; t.write = write; t.abort = abort; t.addr = addr;
        t.wdata = wdata; t.rdata = rdata; t.exp_cyc = exp_cyc;
        sb.push_back(t);
        if (!abort) begin
            if (is_d) d_exp++;
            else      i_exp++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns in the cycle after the resp (arbiter in DONE), inputs may then change.
    task automatic wait_for(input bit is_d, input string tag);
        bit hit = 0;
        for (int n = 0; n < 30 && !hit; n++) begin
            @(negedge clk);
            #1;
            hit = is_d ? d_resp : i_resp;
        end
        if (!hit) chk(tag, is_d ? d_resp : i_resp, 1);
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers in the fourth serving cycle (3 cycles after the request rises).
    initial begin
        pmem_resp  = 0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 0;
                mcnt      = 0;
            end else if (stray_pulse) begin
                pmem_resp   = 1;
                pmem_rdata  = {32{8'h5A}};
                stray_pulse = 0;
            end else if (mem_en && (pmem_read || pmem_write)) begin
                mcnt++;
                if (mcnt == 4) begin
                    pmem_resp  = 1;
                    pmem_rdata = pmem_write ? '1 : model_rdata(pmem_address);
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new grant and checks it until its resp.
    initial forever begin
        @(negedge clk);
        #1;
        serving = pmem_read | pmem_write;
        if (serving && !active) begin
            if (sb.size() == 0) begin
                chk("spurious_grant", {pmem_read, pmem_write}, 0);
            end else begin
                cur    = sb.pop_front();
                active = 1;
                chk("grant_cycle", cyc, (cur.exp_cyc < 0) ? last_resp + 3 : cur.exp_cyc);
            end
        end else if (!serving && active) begin
            if (!cur.abort) chk("serve_dropped", serving, 1);
            active = 0;
        end
        if (serving && active) begin
            chk("pmem_op", {pmem_read, pmem_write}, cur.write ? 2'b01 : 2'b10);
            chk("pmem_addr", pmem_address, cur.addr);
            if (cur.write) chk("pmem_wdata", pmem_wdata, cur.wdata);
        end else if (!serving) begin
            chk("idle_addr", pmem_address, 0);
            chk("idle_wdata", pmem_wdata, 0);
        end
        if (pmem_resp && active) begin
            chk("i_resp_route", i_resp, !cur.is_d);
            chk("d_resp_route", d_resp, cur.is_d);
            if (!cur.write) chk("rdata", cur.is_d ? d_rdata : i_rdata, cur.rdata);
            last_resp = cyc;
            active    = 0;
        end else begin
            chk("resp_quiet", {i_resp, d_resp}, 0);
        end
        i_cnt += int'(i_resp);
        d_cnt += int'(d_resp);
    end

    initial begin
        rst = 0; i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        #3;
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_resp", {i_resp, d_resp}, 0);
        chk("rst_wait_cnt", dut.wait_cnt, 0);
        tick(3);
        rst = 1;
        tick(2);

        // lone icache miss
        i_read = 1; i_address = 32'h4000_0020;
        push(0, 0, 0, 32'h4000_0020, '0, {32{8'hA5}}, cyc + 1);
        wait_for(0, "timeout_lone_i");
        i_read = 0;
        tick(2);

        // simultaneous misses: dcache first, icache after the DONE gap
        i_read = 1; i_address = 32'h4000_0100;
        d_read = 1; d_address = 32'h3000_0080;
        push(1, 0, 0, 32'h3000_0080, '0, model_rdata(32'h3000_0080), cyc + 1);
        push(0, 0, 0, 32'h4000_0100, '0, model_rdata(32'h4000_0100), -1);
        wait_for(1, "timeout_sim_d");
        d_read = 0;
        wait_for(0, "timeout_sim_i");
        i_read = 0;
        tick(2);

        // write-back with requester inputs changing after the grant
        d_write = 1; d_address = 32'h1000_0040; d_wdata = {8{32'h1234_5678}};
        push(1, 1, 0, 32'h1000_0040, {8{32'h1234_5678}}, '0, cyc + 1);
        tick(1);
        d_wdata = '1; d_address = 32'hDEAD_0000;
        wait_for(1, "timeout_wb");
        d_write = 0;
        tick(2);

        // starvation guard at MAX_WAIT=2, read+write collapses to a write
        i_read = 1; i_address = 32'h4000_1000;
        d_read = 1; d_write = 1; d_address = 32'h2000_0000; d_wdata = {8{32'hCAFE_0001}};
        push(1, 1, 0, 32'h2000_0000, {8{32'hCAFE_0001}}, '0, cyc + 1);
        push(1, 0, 0, 32'h2000_0020, '0, model_rdata(32'h2000_0020), -1);
        push(0, 0, 0, 32'h4000_1000, '0, model_rdata(32'h4000_1000), -1);
        push(1, 0, 0, 32'h2000_0040, '0, model_rdata(32'h2000_0040), -1);
        wait_for(1, "timeout_starve_d0");
        chk("wait_cnt_1", dut.wait_cnt, 1);
        d_write = 0; d_address = 32'h2000_0020;
        wait_for(1, "timeout_starve_d1");
        chk("wait_cnt_2", dut.wait_cnt, 2);
        d_address = 32'h2000_0040;
        wait_for(0, "timeout_starve_i");
        chk("wait_cnt_clear", dut.wait_cnt, 0);
        i_read = 0;
        wait_for(1, "timeout_starve_d2");
        d_read = 0;
        tick(2);

        // async reset in the middle of a write-back
        mem_en = 0;
        d_write = 1; d_address = 32'h1000_0080; d_wdata = {8{32'h0BAD_F00D}};
        push(1, 1, 1, 32'h1000_0080, {8{32'h0BAD_F00D}}, '0, cyc + 1);
        tick(2);
        chk("pre_rst_write", pmem_write, 1);
        #1;
        rst = 0;
        #1;
        chk("async_rst_write", pmem_write, 0);
        chk("async_rst_read", pmem_read, 0);
        chk("async_rst_addr", pmem_address, 0);
        d_write = 0;
        tick(2);
        rst = 1;
        mem_en = 1;
        tick(1);
        stray_pulse = 1;
        tick(3);
        chk("post_rst_wait_cnt", dut.wait_cnt, 0);

        // icache drops its request one cycle after the grant
        i_read = 1; i_address = 32'h4000_2000;
        push(0, 0, 0, 32'h4000_2000, '0, model_rdata(32'h4000_2000), cyc + 1);
        tick(1);
        i_read = 0; i_address = 32'h0;
        wait_for(0, "timeout_drop_i");
        tick(10);

        chk("sb_empty", sb.size(), 0);
        chk("i_resp_count", i_cnt, i_exp);
        chk("d_resp_count", d_cnt, d_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port (cacheline adaptor side) between the instruction cache and the data cache.
- Both caches issue 256-bit line misses.
- The arbiter grants one miss at a time, latches the winning request, drives the memory port, and routes the response back to the winner.
- Instruction fetch and MEM-stage accesses are therefore serialized without either cache knowing about the other.

Parameters:
- ADDR_W, 32, physical address width.
- LINE_W, 256, cache line width in bits.
- MAX_WAIT, 4, consecutive data grants allowed while an instruction request waits before the instruction request is forced to win; range 1-15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- i_read  in  1  icache line read request.
- i_address  in  ADDR_W  icache line address (line-aligned).
- i_rdata  out  LINE_W  line data returned to the icache.
- i_resp  out  1  icache transaction complete.
- d_read  in  1  dcache line read request.
- d_write  in  1  dcache line write-back request.
- d_address  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache write-back data.
- d_rdata  out  LINE_W  line data returned to the dcache.
- d_resp  out  1  dcache transaction complete.
- pmem_read  out  1  memory line read.
- pmem_write  out  1  memory line write.
- pmem_address  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory transaction complete; single-cycle pulse.

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- Reset (rst=0, asynchronous): state=IDLE, wait_cnt=0. pmem_read, pmem_write, pmem_address and pmem_wdata are 0. i_resp and d_resp are 0.
- Grant decision happens in IDLE only. d_req = d_read|d_write.
  - Only one request present: that requester wins.
  - Both present: dcache wins unless wait_cnt==MAX_WAIT, in which case the icache wins.
  - None present: stay in IDLE.
- Latch at grant:
  - On the grant edge, latch address, op and (for the dcache) wdata into internal registers.
  - Go to SERVE_I or SERVE_D.
  - A dcache request with d_read and d_write both 1 is latched as a write.
- Drive while serving:
  - In SERVE_x, the pmem_* outputs come from the latched registers only. Later changes on requester inputs are ignored.
  - Exactly one of pmem_read or pmem_write is 1 while serving.
  - The pmem_* outputs are 0 in IDLE and DONE.
- Latency: a request seen in IDLE at edge N is visible on pmem_* in cycle N+1.
- Response routing:
  - In SERVE_x with pmem_resp=1, x_resp=1 in that same cycle (combinational).
  - x_rdata=pmem_rdata during that cycle for reads. For writes, d_resp still pulses and d_rdata is don't-care.
  - The non-granted resp stays 0.
  - Next state is DONE.
- DONE lasts one cycle, then the FSM goes to IDLE.
  - This gives the requester a cycle to deassert its request, so the same miss is never re-granted.
  - Minimum spacing is therefore resp, DONE, IDLE evaluate, new grant.
- Starvation counter (wait_cnt, saturating at MAX_WAIT):
  - Increment on each SERVE_D grant made while i_read=1.
  - Clear on any SERVE_I grant.
  - Clear when a grant is made with i_read=0.
- Requester drops its request mid-service: the transaction still completes and the resp pulse is still routed to it.
- Reset mid-transaction: return immediately to IDLE with all outputs 0. A late pmem_resp arriving in IDLE is ignored; no resp is generated.
- pmem_resp outside SERVE_x is ignored.
- The i_rdata and d_rdata outputs pass pmem_rdata through combinationally. They are only meaningful while the matching resp=1.

Test Plan:
- Lone icache miss:
  - Stimulus: i_read=1, i_address=0x4000_0020. pmem_resp pulses 3 cycles after pmem_read rises, with pmem_rdata=256'hA5...A5.
  - Required: pmem_read=1 with pmem_address=0x4000_0020 one cycle after the request. i_resp=1 and i_rdata=A5...A5 in the resp cycle. d_resp=0 throughout.
- Simultaneous misses:
  - Stimulus: i_read=1 and d_read=1 in the same IDLE cycle.
  - Required: the dcache address is served first. After d_resp, one DONE cycle, then the icache is served. Exactly one i_resp pulse and one d_resp pulse.
- Write-back latching:
  - Stimulus: d_write=1, d_address=0x1000_0040, d_wdata=256'h1234...; change d_wdata and d_address one cycle after the grant.
  - Required: pmem_write=1 with the original values held until pmem_resp. pmem_read=0 throughout.
- Starvation guard, MAX_WAIT=2:
  - Stimulus: i_read held at 1 while the dcache issues back-to-back misses.
  - Required: the dcache wins twice, then the icache wins the third arbitration. wait_cnt returns to 0 after the icache grant.
- Async reset mid-service:
  - Stimulus: assert rst=0 mid-cycle during SERVE_D.
  - Required: pmem_write and pmem_read drop to 0 without waiting for a clock edge. A pmem_resp arriving after rst=1 produces no d_resp.
- Requester drop:
  - Stimulus: the icache deasserts i_read one cycle after the grant.
  - Required: pmem_read stays 1 until pmem_resp, i_resp still pulses, and no second grant is made afterwards.
